// File: rtl/multi_cycle_control.sv
// Moore control FSM for a multi-cycle MIPS-style datapath with a memory ready
// handshake; outputs decode from the current state (plus mem_ready_i / op_i where noted).
module multi_cycle_control #(
  parameter int unsigned ORI_ZERO_EXT = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] op_i,
  input  logic       mem_ready_i,
  input  logic       zero_i,
  output logic       pc_write_o,
  output logic       pc_write_cond_o,
  output logic       iord_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic       ext_op_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] pc_source_o,
  output logic [3:0] state_o,
  output logic       illegal_o
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_RWB    = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_IEXEC  = 4'd9;
  localparam logic [3:0] S_IWB    = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM4 = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OR    = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  localparam logic ORI_EXT = (ORI_ZERO_EXT != 0) ? 1'b0 : 1'b1;

  logic [3:0] state_q, state_d;
  logic       is_ori;
  logic       imm_ext;

  // op_i is held by the IR after FETCH, so it can steer IEXEC/IWB directly.
  assign is_ori  = (op_i == OP_ORI);
  assign imm_ext = is_ori ? ORI_EXT : 1'b1;
  assign state_o = state_q;

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op_i)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI,
          OP_ORI:       state_d = S_IEXEC;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (op_i == OP_LW)      state_d = S_MEMRD;
        else if (op_i == OP_SW) state_d = S_MEMWR;
        else                    state_d = S_FETCH;
      end
      S_MEMRD:  state_d = mem_ready_i ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mem_ready_i ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_RWB;
      S_RWB:    state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_IEXEC:  state_d = S_IWB;
      S_IWB:    state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    iord_o          = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    ir_write_o      = 1'b0;
    reg_dst_o       = 1'b0;
    mem_to_reg_o    = 1'b0;
    reg_write_o     = 1'b0;
    alu_src_a_o     = 1'b0;
    ext_op_o        = 1'b1;
    alu_src_b_o     = SRCB_REG;
    alu_op_o        = ALU_ADD;
    pc_source_o     = PCS_ALU;
    illegal_o       = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = SRCB_FOUR;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
      end
      S_DECODE: begin
        alu_src_b_o = SRCB_IMM4;
        illegal_o   = !(op_i inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ,
                                     OP_ADDI, OP_ORI, OP_J});
      end
      S_MEMADR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_read_o = 1'b1;
        iord_o     = 1'b1;
      end
      S_MEMWB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      S_MEMWR: begin
        mem_write_o = 1'b1;
        iord_o      = 1'b1;
      end
      S_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_FUNCT;
      end
      S_RWB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_o     = 1'b1;
        alu_op_o        = ALU_SUB;
        pc_write_cond_o = 1'b1;
        pc_source_o     = PCS_ALUOUT;
      end
      S_IEXEC: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
        alu_op_o    = is_ori ? ALU_OR : ALU_ADD;
        ext_op_o    = imm_ext;
      end
      S_IWB: begin
        reg_write_o = 1'b1;
        ext_op_o    = imm_ext;
      end
      S_JUMP: begin
        pc_write_o  = 1'b1;
        pc_source_o = PCS_JUMP;
      end
      // Encodings 12-15 are unreachable; drive everything low, extender included.
      default: ext_op_o = 1'b0;
    endcase
    if (rst_i) begin
      pc_write_o      = 1'b0;
      pc_write_cond_o = 1'b0;
      iord_o          = 1'b0;
      mem_read_o      = 1'b0;
      mem_write_o     = 1'b0;
      ir_write_o      = 1'b0;
      reg_dst_o       = 1'b0;
      mem_to_reg_o    = 1'b0;
      reg_write_o     = 1'b0;
      alu_src_a_o     = 1'b0;
      ext_op_o        = 1'b1;
      alu_src_b_o     = SRCB_REG;
      alu_op_o        = ALU_ADD;
      pc_source_o     = PCS_ALU;
      illegal_o       = 1'b0;
    end
  end

  // zero_i only gates the PC externally; here it must at least be defined when branching.
  always_ff @(posedge clk_i) begin
    if (!rst_i && state_q == S_BRANCH) assert (!$isunknown(zero_i));
  end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Scoreboard bench for multi_cycle_control: stimulus pushes hand-written expected
// state/control vectors, a negedge monitor pops and compares them.
module tb_multi_cycle_control;

  logic       clk, rst;
  logic [5:0] op;
  logic       rdy, zero;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, ext_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
  logic       illegal;

  multi_cycle_control #(.ORI_ZERO_EXT(1)) dut (
    .clk_i(clk), .rst_i(rst), .op_i(op), .mem_ready_i(rdy), .zero_i(zero),
    .pc_write_o(pc_write), .pc_write_cond_o(pc_write_cond), .iord_o(iord),
    .mem_read_o(mem_read), .mem_write_o(mem_write), .ir_write_o(ir_write),
    .reg_dst_o(reg_dst), .mem_to_reg_o(mem_to_reg), .reg_write_o(reg_write),
    .alu_src_a_o(alu_src_a), .ext_op_o(ext_op), .alu_src_b_o(alu_src_b),
    .alu_op_o(alu_op), .pc_source_o(pc_source), .state_o(state),
    .illegal_o(illegal)
  );

  // Control vector layout:
  // {pcw,pcwc,iord,mrd,mwr,irw}_{rdst,m2r,rw,asa,ext}_asb_aop_psrc_ill
  localparam logic [17:0] C_RST    = 18'b000000_00001_00_00_00_0;
  localparam logic [17:0] C_FETCH  = 18'b100101_00001_01_00_00_0;
  localparam logic [17:0] C_FETCHW = 18'b000100_00001_01_00_00_0;
  localparam logic [17:0] C_DECODE = 18'b000000_00001_11_00_00_0;
  localparam logic [17:0] C_DECILL = 18'b000000_00001_11_00_00_1;
  localparam logic [17:0] C_MEMADR = 18'b000000_00011_10_00_00_0;
  localparam logic [17:0] C_MEMRD  = 18'b001100_00001_00_00_00_0;
  localparam logic [17:0] C_MEMWB  = 18'b000000_01101_00_00_00_0;
  localparam logic [17:0] C_MEMWR  = 18'b001010_00001_00_00_00_0;
  localparam logic [17:0] C_EXEC   = 18'b000000_00011_00_10_00_0;
  localparam logic [17:0] C_RWB    = 18'b000000_10101_00_00_00_0;
  localparam logic [17:0] C_BRANCH = 18'b010000_00011_00_01_01_0;
  localparam logic [17:0] C_IEX_AD = 18'b000000_00011_10_00_00_0;
  localparam logic [17:0] C_IEX_OR = 18'b000000_00010_10_11_00_0;
  localparam logic [17:0] C_IWB_AD = 18'b000000_00101_00_00_00_0;
  localparam logic [17:0] C_IWB_OR = 18'b000000_00100_00_00_00_0;
  localparam logic [17:0] C_JUMP   = 18'b100000_00001_00_00_10_0;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, ORI = 6'b001101;
  localparam logic [5:0] JMP = 6'b000010, BAD = 6'b111111;

  typedef struct {
    string       tag;
    logic [3:0]  st;
    logic [17:0] ctl;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the outputs expected during that cycle.
  task automatic step(input string tag, input logic r, input logic [5:0] o,
                      input logic m, input logic [3:0] st, input logic [17:0] ctl);
    exp_t e;
    @(posedge clk);
    #1;
    rst  = r;
    op   = o;
    rdy  = m;
    zero = 1'($urandom_range(0, 1));
    e.tag = tag;
    e.st  = st;
    e.ctl = ctl;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      logic [17:0] act;
      e = sb_q.pop_front();
      act = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
             reg_dst, mem_to_reg, reg_write, alu_src_a, ext_op,
             alu_src_b, alu_op, pc_source, illegal};
      checks++;
      if (state !== e.st) begin
        errors++;
        $display("FAIL %s state: got %0d expected %0d", e.tag, state, e.st);
      end
      checks++;
      if (act !== e.ctl) begin
        errors++;
        $display("FAIL %s ctl: got %b expected %b", e.tag, act, e.ctl);
      end
    end
  end

  initial begin
    rst = 1'b1; op = RT; rdy = 1'b1; zero = 1'b0;
    step("rst0", 1, RT, 1, 4'd0, C_RST);
    step("rst1", 1, RT, 1, 4'd0, C_RST);
    // lw, no waits: 5 cycles
    step("lw_f",  0, LW, 1, 4'd0, C_FETCH);
    step("lw_d",  0, LW, 1, 4'd1, C_DECODE);
    step("lw_a",  0, LW, 1, 4'd2, C_MEMADR);
    step("lw_r",  0, LW, 1, 4'd3, C_MEMRD);
    step("lw_wb", 0, LW, 1, 4'd4, C_MEMWB);
    // sw with three wait cycles in MEMWR
    step("sw_f",  0, SW, 1, 4'd0, C_FETCH);
    step("sw_d",  0, SW, 1, 4'd1, C_DECODE);
    step("sw_a",  0, SW, 1, 4'd2, C_MEMADR);
    step("sw_w0", 0, SW, 0, 4'd5, C_MEMWR);
    step("sw_w1", 0, SW, 0, 4'd5, C_MEMWR);
    step("sw_w2", 0, SW, 0, 4'd5, C_MEMWR);
    step("sw_w3", 0, SW, 1, 4'd5, C_MEMWR);
    // ori with zero extension
    step("ori_f", 0, ORI, 1, 4'd0, C_FETCH);
    step("ori_d", 0, ORI, 1, 4'd1, C_DECODE);
    step("ori_x", 0, ORI, 1, 4'd9, C_IEX_OR);
    step("ori_w", 0, ORI, 1, 4'd10, C_IWB_OR);
    // addi
    step("adi_f", 0, ADDI, 1, 4'd0, C_FETCH);
    step("adi_d", 0, ADDI, 1, 4'd1, C_DECODE);
    step("adi_x", 0, ADDI, 1, 4'd9, C_IEX_AD);
    step("adi_w", 0, ADDI, 1, 4'd10, C_IWB_AD);
    // R-type
    step("rt_f", 0, RT, 1, 4'd0, C_FETCH);
    step("rt_d", 0, RT, 1, 4'd1, C_DECODE);
    step("rt_x", 0, RT, 1, 4'd6, C_EXEC);
    step("rt_w", 0, RT, 1, 4'd7, C_RWB);
    // beq
    step("beq_f", 0, BEQ, 1, 4'd0, C_FETCH);
    step("beq_d", 0, BEQ, 1, 4'd1, C_DECODE);
    step("beq_b", 0, BEQ, 1, 4'd8, C_BRANCH);
    // j
    step("j_f", 0, JMP, 1, 4'd0, C_FETCH);
    step("j_d", 0, JMP, 1, 4'd1, C_DECODE);
    step("j_j", 0, JMP, 1, 4'd11, C_JUMP);
    // unknown opcode
    step("ill_f", 0, BAD, 1, 4'd0, C_FETCH);
    step("ill_d", 0, BAD, 1, 4'd1, C_DECILL);
    // FETCH waits on memory for two cycles
    step("fw_0", 0, RT, 0, 4'd0, C_FETCHW);
    step("fw_1", 0, RT, 0, 4'd0, C_FETCHW);
    step("fw_2", 0, RT, 1, 4'd0, C_FETCH);
    step("fw_d", 0, RT, 1, 4'd1, C_DECODE);
    step("fw_x", 0, RT, 1, 4'd6, C_EXEC);
    step("fw_w", 0, RT, 1, 4'd7, C_RWB);
    // reset while lw is stalled in MEMRD: no register write may follow
    step("rl_f",   0, LW, 1, 4'd0, C_FETCH);
    step("rl_d",   0, LW, 1, 4'd1, C_DECODE);
    step("rl_a",   0, LW, 1, 4'd2, C_MEMADR);
    step("rl_r0",  0, LW, 0, 4'd3, C_MEMRD);
    step("rl_rst", 1, LW, 0, 4'd3, C_RST);
    step("rl_f2",  0, LW, 1, 4'd0, C_FETCH);
    step("rl_d2",  0, LW, 1, 4'd1, C_DECODE);
    // bounded drain of the scoreboard
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_cycle_control.md
MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 Parameter ORI_ZERO_EXT, default 1; 1 = ori uses zero extension, 0 = ori uses sign extension.
REQ-002 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_i  input  1  reset, synchronous and active-high.
REQ-004 op_i  input  6  opcode field of the instruction register (instr[31:26]).
REQ-005 mem_ready_i  input  1  memory handshake; 1 = current read/write completes this cycle.
REQ-006 zero_i  input  1  ALU zero flag, valid in BRANCH state.
REQ-007 pc_write_o, pc_write_cond_o, iord_o, mem_read_o, mem_write_o, ir_write_o  output  1 each  PC/memory/IR controls.
REQ-008 reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o, ext_op_o  output  1 each  register-file/ALU/extender controls; ext_op_o 1 = sign extend, 0 = zero extend.
REQ-009 alu_src_b_o  output  2  00 = B reg, 01 = constant 4, 10 = extended imm, 11 = extended imm << 2.
REQ-010 alu_op_o  output  2  00 = add, 01 = sub, 10 = funct-decoded, 11 = or.
REQ-011 pc_source_o  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-012 state_o  output  4  current state encoding (debug); illegal_o  output  1  one-cycle unknown-opcode pulse.

Function
REQ-013 Moore FSM; states/encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, IEXEC 9, IWB 10, JUMP 11.
REQ-014 FETCH: mem_read_o=1, iord_o=0, alu_src_a_o=0, alu_src_b_o=01, alu_op_o=00, pc_source_o=00; ir_write_o and pc_write_o = mem_ready_i; stays in FETCH while mem_ready_i=0, else -> DECODE.
REQ-015 DECODE: alu_src_a_o=0, alu_src_b_o=11, alu_op_o=00, ext_op_o=1; next by op_i: 000000 -> EXEC, 100011/101011 -> MEMADR, 000100 -> BRANCH, 001000/001101 -> IEXEC, 000010 -> JUMP, other -> FETCH with illegal_o=1 for that DECODE cycle.
REQ-016 MEMADR: alu_src_a_o=1, alu_src_b_o=10, alu_op_o=00, ext_op_o=1; lw -> MEMRD, sw -> MEMWR (op_i held stable by IR).
REQ-017 MEMRD: mem_read_o=1, iord_o=1; hold until mem_ready_i=1, then -> MEMWB.
REQ-018 MEMWB: reg_write_o=1, reg_dst_o=0, mem_to_reg_o=1; -> FETCH.
REQ-019 MEMWR: mem_write_o=1, iord_o=1; hold until mem_ready_i=1, then -> FETCH.
REQ-020 EXEC: alu_src_a_o=1, alu_src_b_o=00, alu_op_o=10; -> RWB. RWB: reg_write_o=1, reg_dst_o=1, mem_to_reg_o=0; -> FETCH.
REQ-021 BRANCH: alu_src_a_o=1, alu_src_b_o=00, alu_op_o=01, pc_write_cond_o=1, pc_source_o=01; -> FETCH (PC update gated externally by zero_i).
REQ-022 IEXEC: alu_src_a_o=1, alu_src_b_o=10; addi: alu_op_o=00, ext_op_o=1; ori: alu_op_o=11, ext_op_o = ~ORI_ZERO_EXT; -> IWB.
REQ-023 IWB: reg_write_o=1, reg_dst_o=0, mem_to_reg_o=0, ext_op_o as in IEXEC; -> FETCH.
REQ-024 JUMP: pc_write_o=1, pc_source_o=10; -> FETCH.
REQ-025 Any control output not listed for a state is 0 in that state; ext_op_o defaults to 1.
REQ-026 Cycle counts with mem_ready_i=1: R-type 4, lw 5, sw 4, beq 3, addi/ori 4, j 3; each 0-cycle of mem_ready_i in FETCH/MEMRD/MEMWR adds one cycle.
REQ-027 Unused state encodings 12-15 -> FETCH next cycle with all control outputs 0.

Reset
REQ-028 rst_i=1 at a rising edge -> state FETCH, regardless of current state or pending memory wait.
REQ-029 While rst_i=1, all write enables (pc_write_o, pc_write_cond_o, mem_write_o, ir_write_o, reg_write_o) and mem_read_o and illegal_o are forced 0; other outputs 0 except ext_op_o=1.
REQ-030 First cycle after rst_i falls is FETCH with mem_read_o=1.

Verification
REQ-031 Reset 2 cycles, mem_ready_i=1 -> state_o=0, all enables 0 during reset; cycle after: mem_read_o=1, ir_write_o=1, pc_write_o=1.
REQ-032 op_i=100011, mem_ready_i=1 -> state_o 0,1,2,3,4,0; reg_write_o=1 and mem_to_reg_o=1 only in state 4.
REQ-033 op_i=101011, mem_ready_i low 3 cycles in MEMWR -> state_o stays 5 for 4 cycles, mem_write_o=1 throughout, then 0.
REQ-034 op_i=001101, ORI_ZERO_EXT=1 -> states 0,1,9,10; ext_op_o=0 and alu_op_o=11 in 9; addi (001000) gives ext_op_o=1, alu_op_o=00.
REQ-035 op_i=111111 -> states 0,1,0; illegal_o=1 exactly in the DECODE cycle; no write enable asserted.
REQ-036 rst_i=1 while in MEMRD with mem_ready_i=0 -> next state_o=0, reg_write_o never asserted for that lw.
